// File: rtl/ram_req_sequencer.sv
// Read/write front-end for the single-port RAM: range check, strobe gating and in-order response FIFO.
// Define RAMSEQ_STATS_EN to add STAT_RD/STAT_WR/STAT_ERR command counters.
module ram_req_sequencer #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int RAM_SIZE   = 3072,
  parameter int RSP_DEPTH  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic                  REQ_WRITE,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ_WDATA,
  output logic                  RSP_VALID,
  input  logic                  RSP_READY,
  output logic [DATA_WIDTH-1:0] RSP_DATA,
  output logic                  RSP_ERR,
  output logic                  RAM_RDEN,
  output logic                  RAM_WREN,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_WDATA,
  input  logic [DATA_WIDTH-1:0] RAM_RDATA
`ifdef RAMSEQ_STATS_EN
  ,
  output logic [31:0]           STAT_RD,
  output logic [31:0]           STAT_WR,
  output logic [31:0]           STAT_ERR
`endif
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int OW = $clog2(RSP_DEPTH + 2);

  logic                  accept, in_range, push, pop;
  logic                  p_vld_q, p_vld_d, p_rd_q, p_rd_d, p_err_q, p_err_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [PW-1:0]         rd_q, rd_d, wr_q, wr_d;
  logic [OW-1:0]         occ_after;
  logic [DATA_WIDTH-1:0] push_data;
  logic [DATA_WIDTH-1:0] fifo_data [RSP_DEPTH];
  logic                  fifo_err  [RSP_DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A full address space can never be out of range.
  if (RAM_SIZE >= (1 << ADDR_WIDTH)) begin : g_full
    assign in_range = 1'b1;
  end else begin : g_part
    assign in_range = (REQ_ADDR < ADDR_WIDTH'(RAM_SIZE));
  end

  assign RSP_VALID = (cnt_q != '0);
  assign pop       = RSP_VALID & RSP_READY;
  assign push      = p_vld_q;

  // Credit counts the pending stage, so a new accept never overflows the FIFO.
  assign occ_after = OW'(cnt_q) + OW'(p_vld_q) - OW'(pop);
  assign REQ_READY = !RST && (occ_after < OW'(RSP_DEPTH));
  assign accept    = REQ_VALID & REQ_READY;

  assign RAM_RDEN  = accept & !REQ_WRITE & in_range;
  assign RAM_WREN  = accept &  REQ_WRITE & in_range;
  assign RAM_ADDR  = REQ_ADDR;
  assign RAM_WDATA = REQ_WDATA;

  assign push_data = p_rd_q ? RAM_RDATA : '0;
  assign RSP_DATA  = RSP_VALID ? fifo_data[rd_q] : '0;
  assign RSP_ERR   = RSP_VALID ? fifo_err[rd_q]  : 1'b0;

  always_comb begin
    p_vld_d = accept;
    p_rd_d  = accept & !REQ_WRITE & in_range;
    p_err_d = accept & !in_range;
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    rd_d    = pop  ? ptr_inc(rd_q) : rd_q;
    wr_d    = push ? ptr_inc(wr_q) : wr_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      p_vld_q <= 1'b0;
      p_rd_q  <= 1'b0;
      p_err_q <= 1'b0;
      cnt_q   <= '0;
      rd_q    <= '0;
      wr_q    <= '0;
    end else begin
      p_vld_q <= p_vld_d;
      p_rd_q  <= p_rd_d;
      p_err_q <= p_err_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
    end
  end

  // Payload storage needs no reset; RSP_* are masked while the FIFO is empty.
  always_ff @(posedge CLK) begin
    if (push && !RST) begin
      fifo_data[wr_q] <= push_data;
      fifo_err[wr_q]  <= p_err_q;
    end
  end

`ifdef RAMSEQ_STATS_EN
  logic [31:0] st_rd_q, st_rd_d, st_wr_q, st_wr_d, st_err_q, st_err_d;

  always_comb begin
    st_rd_d  = st_rd_q  + 32'(RAM_RDEN);
    st_wr_d  = st_wr_q  + 32'(RAM_WREN);
    st_err_d = st_err_q + 32'(accept & !in_range);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_rd_q  <= '0;
      st_wr_q  <= '0;
      st_err_q <= '0;
    end else begin
      st_rd_q  <= st_rd_d;
      st_wr_q  <= st_wr_d;
      st_err_q <= st_err_d;
    end
  end

  assign STAT_RD  = st_rd_q;
  assign STAT_WR  = st_wr_q;
  assign STAT_ERR = st_err_q;
`endif

endmodule

// File: tb/tb_ram_req_sequencer.sv
// Directed bench for ram_req_sequencer with a behavioural RAM and an in-order response scoreboard.
module tb_ram_req_sequencer;
  localparam int AW = 12;
  localparam int DW = 16;
  localparam int RS = 3072;
  localparam int RD = 2;

  logic          CLK = 1'b0;
  logic          RST, REQ_VALID, REQ_READY, REQ_WRITE;
  logic [AW-1:0] REQ_ADDR, RAM_ADDR;
  logic [DW-1:0] REQ_WDATA, RSP_DATA, RAM_WDATA, RAM_RDATA;
  logic          RSP_VALID, RSP_READY, RSP_ERR, RAM_RDEN, RAM_WREN;
`ifdef RAMSEQ_STATS_EN
  logic [31:0]   STAT_RD, STAT_WR, STAT_ERR;
`endif

  ram_req_sequencer #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RAM_SIZE(RS), .RSP_DEPTH(RD)) dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE),
    .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR),
    .RAM_RDEN(RAM_RDEN), .RAM_WREN(RAM_WREN), .RAM_ADDR(RAM_ADDR),
    .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA)
`ifdef RAMSEQ_STATS_EN
    , .STAT_RD(STAT_RD), .STAT_WR(STAT_WR), .STAT_ERR(STAT_ERR)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] data;
    logic          err;
    int            acc_cyc;
    bit            lat;
  } exp_t;

  exp_t          q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  int            cyc     = 0;
  bit            lat_chk = 0;
  logic [DW-1:0] ram_mem [1<<AW];
  logic [DW-1:0] model   [1<<AW];

  // Single-port RAM with one-cycle registered read.
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (RAM_WREN) ram_mem[RAM_ADDR] <= RAM_WDATA;
    if (RAM_RDEN) RAM_RDATA <= ram_mem[RAM_ADDR];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: push on accept, compare the FIFO head whenever a response is shown.
  always @(negedge CLK) begin
    exp_t e;
    bit   acc, inr;
    if (RST) begin
      q.delete();
    end else begin
      if (RSP_VALID) begin
        chk("rsp_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          e = q[0];
          chk("rsp_data", 32'(RSP_DATA), 32'(e.data));
          chk("rsp_err", 32'(RSP_ERR), 32'(e.err));
          if (RSP_READY) begin
            void'(q.pop_front());
            if (e.lat) chk("latency", 32'(cyc - e.acc_cyc), 32'd2);
          end
        end
      end
      acc = REQ_VALID && REQ_READY;
      inr = (32'(REQ_ADDR) < RS);
      chk("ram_rden", 32'(RAM_RDEN), 32'(acc && !REQ_WRITE && inr));
      chk("ram_wren", 32'(RAM_WREN), 32'(acc && REQ_WRITE && inr));
      chk("ram_addr", 32'(RAM_ADDR), 32'(REQ_ADDR));
      if (acc) begin
        e.data    = (!REQ_WRITE && inr) ? model[REQ_ADDR] : '0;
        e.err     = !inr;
        e.acc_cyc = cyc;
        e.lat     = lat_chk;
        q.push_back(e);
        if (REQ_WRITE && inr) model[REQ_ADDR] = REQ_WDATA;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    REQ_VALID = 1'b0;
    REQ_WRITE = 1'b0;
  endtask

  task automatic drive(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    REQ_VALID = 1'b1;
    REQ_WRITE = w;
    REQ_ADDR  = a;
    REQ_WDATA = d;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || RSP_VALID) && n < 50) begin
      step();
      n++;
    end
    chk("drain_in_time", 32'(n < 50), 32'd1);
  endtask

  initial begin
    int i, n_acc, guard;
    bit acc;
    RST = 1'b1; RSP_READY = 1'b1; REQ_ADDR = '0; REQ_WDATA = '0;
    idle();
    step(); step();

    // Reset: outputs quiet and no accept even with a valid command offered.
    drive(0, 12'h000, 16'h0);
    @(negedge CLK);
    chk("rst_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst_rsp_data", 32'(RSP_DATA), 32'd0);
    chk("rst_rsp_err", 32'(RSP_ERR), 32'd0);
    chk("rst_req_ready", 32'(REQ_READY), 32'd0);
    chk("rst_rden", 32'(RAM_RDEN), 32'd0);
    chk("rst_wren", 32'(RAM_WREN), 32'd0);
    step();
    idle();
    RST = 1'b0;

    // Write then read the same address on consecutive cycles.
    drive(1, 12'h010, 16'hBEEF);
    @(negedge CLK);
    chk("t1_ready", 32'(REQ_READY), 32'd1);
    chk("t1_wren", 32'(RAM_WREN), 32'd1);
    chk("t1_rden", 32'(RAM_RDEN), 32'd0);
    step();
    drive(0, 12'h010, 16'h0);
    @(negedge CLK);
    chk("t1_rden2", 32'(RAM_RDEN), 32'd1);
    chk("t1_wren2", 32'(RAM_WREN), 32'd0);
    step();
    idle();
    drain();

    // Range boundary.
    drive(1, 12'hBFF, 16'h5A5A);
    step();
    drive(0, 12'hC00, 16'h0);
    @(negedge CLK);
    chk("t2_oor_rden", 32'(RAM_RDEN), 32'd0);
    chk("t2_oor_ready", 32'(REQ_READY), 32'd1);
    step();
    drive(0, 12'hBFF, 16'h0);
    @(negedge CLK);
    chk("t2_last_rden", 32'(RAM_RDEN), 32'd1);
    step();
    drive(0, 12'hFFF, 16'h0);
    step();
    idle();
    drain();

    // Preload 0..7, then back-to-back reads with fixed 2-cycle latency.
    for (int k = 0; k < 8; k++) begin
      drive(1, AW'(k), DW'(16'h1000 + k));
      step();
    end
    lat_chk = 1;
    for (int k = 0; k < 8; k++) begin
      drive(0, AW'(k), 16'h0);
      @(negedge CLK);
      chk("b2b_ready", 32'(REQ_READY), 32'd1);
      step();
    end
    idle();
    drain();
    lat_chk = 0;

    // Backpressure: only RSP_DEPTH commands outstanding.
    RSP_READY = 1'b0;
    i = 0; n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      drive(0, AW'(i), 16'h0);
      @(negedge CLK);
      acc = REQ_READY;
      step();
      if (acc) begin i++; n_acc++; end
    end
    chk("bp_accepted", 32'(n_acc), 32'd2);
    @(negedge CLK);
    chk("bp_ready_low", 32'(REQ_READY), 32'd0);
    step();
    RSP_READY = 1'b1;
    guard = 0;
    while (i < 4 && guard < 20) begin
      drive(0, AW'(i), 16'h0);
      @(negedge CLK);
      acc = REQ_READY;
      step();
      if (acc) i++;
      guard++;
    end
    chk("bp_all_accepted", 32'(i), 32'd4);
    idle();
    drain();

    // Reset with two responses pending drops them.
    RSP_READY = 1'b0;
    n_acc = 0; guard = 0;
    while (n_acc < 2 && guard < 10) begin
      drive(0, 12'h010, 16'h0);
      @(negedge CLK);
      acc = REQ_READY;
      step();
      if (acc) n_acc++;
      guard++;
    end
    chk("rst2_pending", 32'(n_acc), 32'd2);
    idle();
    RST = 1'b1;
    @(negedge CLK);
    chk("rst2_req_ready", 32'(REQ_READY), 32'd0);
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("rst2_rsp_valid", 32'(RSP_VALID), 32'd0);
    chk("rst2_rsp_err", 32'(RSP_ERR), 32'd0);
    RSP_READY = 1'b1;
    repeat (5) step();
    chk("rst2_no_stale", 32'(q.size()), 32'd0);

`ifdef RAMSEQ_STATS_EN
    RST = 1'b1;
    step();
    RST = 1'b0;
    drive(0, 12'h010, 16'h0); step();
    drive(1, 12'h020, 16'h1111); step();
    drive(0, 12'h000, 16'h0); step();
    drive(0, 12'hC00, 16'h0); step();
    drive(1, 12'h021, 16'h2222); step();
    drive(0, 12'h001, 16'h0); step();
    idle();
    drain();
    chk("stat_rd", STAT_RD, 32'd3);
    chk("stat_wr", STAT_WR, 32'd2);
    chk("stat_err", STAT_ERR, 32'd1);
    RST = 1'b1;
    step();
    RST = 1'b0;
    @(negedge CLK);
    chk("stat_rd_rst", STAT_RD, 32'd0);
    chk("stat_wr_rst", STAT_WR, 32'd0);
    chk("stat_err_rst", STAT_ERR, 32'd0);
    step();
`endif

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_req_sequencer.md
Name: ram_req_sequencer

Overview:
Request front-end that sits directly upstream of the single-port RAM stage. It accepts read/write commands on a valid/ready stream and range-checks each address against RAM_SIZE. It drives the RAM strobes (RDEN/WREN, ADDR, IN_DATA) and captures the registered read data (OUT_DATA). Every command returns exactly one in-order response through a small response FIFO with backpressure.

Parameters:
ADDR_WIDTH, 12, width of request and RAM address
DATA_WIDTH, 16, width of write/read data
RAM_SIZE, 3072, number of valid RAM words; addresses >= RAM_SIZE are errors
RSP_DEPTH, 2, response FIFO entries (>= 2)

Ports:
CLK  in  1  clock, all logic on posedge
RST  in  1  reset, synchronous, active-high
REQ_VALID  in  1  command valid
REQ_READY  out  1  command accepted when VALID&READY at posedge
REQ_WRITE  in  1  1 = write, 0 = read
REQ_ADDR  in  ADDR_WIDTH  command address
REQ_WDATA  in  DATA_WIDTH  write data
RSP_VALID  out  1  response valid
RSP_READY  in  1  response consumed when VALID&READY at posedge
RSP_DATA  out  DATA_WIDTH  read data; 0 for writes and errors
RSP_ERR  out  1  1 = address out of range
RAM_RDEN  out  1  to RAM RDEN
RAM_WREN  out  1  to RAM WREN
RAM_ADDR  out  ADDR_WIDTH  to RAM ADDR
RAM_WDATA  out  DATA_WIDTH  to RAM IN_DATA
RAM_RDATA  in  DATA_WIDTH  from RAM OUT_DATA

Behaviour:
- Reset (RST=1 at posedge): pending stage and FIFO cleared, so RSP_VALID=0, RSP_DATA=0, RSP_ERR=0. REQ_READY=0 combinationally while RST=1. RAM_RDEN=RAM_WREN=0. In-flight responses are dropped, not replayed.
- accept = REQ_VALID & REQ_READY; in_range = REQ_ADDR < RAM_SIZE (unsigned compare, full width).
- RAM_RDEN = accept & !REQ_WRITE & in_range; RAM_WREN = accept & REQ_WRITE & in_range. Both are combinational, so the RAM samples on the accept edge. They are never both 1.
- RAM_ADDR = REQ_ADDR and RAM_WDATA = REQ_WDATA (pass-through); only the strobes are gated.
- Out-of-range command: no RAM strobe, response queued with RSP_ERR=1 and RSP_DATA=0.
- Pending stage P (valid, is_read, err) loads on accept edge k. At edge k+1, P pushes into the FIFO with data = (is_read & !err) ? RAM_RDATA : 0. RAM_RDATA is valid in that cycle per the RAM's 1-cycle read latency.
- Latency: command accepted at edge k, RSP_VALID=1 in the cycle after edge k+1 (2 cycles). Order is strictly preserved.
- Credit: occ = fifo_count + P.valid; pop = RSP_VALID & RSP_READY.
  - REQ_READY = !RST & ((occ - pop) < RSP_DEPTH).
  - RSP_READY feeds REQ_READY combinationally.
- Throughput: 1 command/cycle sustained while RSP_READY=1. With RSP_READY=0, at most RSP_DEPTH responses are outstanding, then REQ_READY=0.
- FIFO full plus push and pop in the same cycle: legal, count unchanged. Pop on empty: impossible, since RSP_VALID=0 when empty.
- FIFO head drives RSP_*; the head is held stable while RSP_VALID=1 & RSP_READY=0.
- Write followed by read to the same address on consecutive cycles returns the new data; the RAM commits the write at the first edge.
- RAM_SIZE == 2**ADDR_WIDTH means no address is ever an error.

Optional Feature:
Macro RAMSEQ_STATS_EN.
- Defined: adds outputs STAT_RD, STAT_WR, STAT_ERR (32 bits each). Each increments by 1 on an accepted in-range read, an accepted in-range write, or an accepted out-of-range command respectively. Counters wrap modulo 2^32 and clear on RST.
- Not defined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset, then write addr 0x010 data 0xBEEF, then read 0x010 on the next cycle -> two responses in order: (DATA=0, ERR=0) then (DATA=0xBEEF, ERR=0); RAM_WREN=1 then RAM_RDEN=1, never both.
- Read addr 0xC00 (3072) -> no RAM strobe; response DATA=0, ERR=1. Read 0xBFF -> ERR=0.
- Hold RSP_READY=0 and offer 4 reads -> exactly 2 accepted, REQ_READY=0. Raise RSP_READY -> responses drain in order and the remaining reads are accepted.
- Back-to-back reads of 0x000..0x007 (preloaded 0x1000+i) with RSP_READY=1 -> REQ_READY stays 1, one response per cycle, 2-cycle latency, data 0x1000..0x1007.
- Assert RST for 1 cycle with 2 responses pending -> RSP_VALID=0 the next cycle, REQ_READY=0 during RST, and no stale responses afterwards.
- With RAMSEQ_STATS_EN: 3 reads, 2 writes, 1 out-of-range -> STAT_RD=3, STAT_WR=2, STAT_ERR=1; all return to 0 after RST.
